motor_ramp_scheduler: RTL
=========================

Name: motor_ramp_scheduler

Overview:
- Command front-end for a bank of H-bridge motor_controller channels.
- Accepts per-motor set-points (dir, on, 5-bit duty) over a valid/ready port and drives each channel's dir/on/duty inputs.
- Slews duty one LSB per ramp tick, so channels never step abruptly.
- Sequences direction reversal safely: ramp down to 0, turn off, hold, flip dir, then ramp up.

Parameters:
- NUM_MOTORS, 6, number of channels managed.
- IDX_W, 3, width of cmd_motor; must satisfy 2^IDX_W >= NUM_MOTORS.
- RAMP_DIV, 50000, clk cycles per ramp tick (1 ms at 50 MHz); legal range 2..2^20.
- HOLD_TICKS, 20, ramp ticks spent off in HOLD before re-enabling; legal range 1..255.
- WDT_TICKS, 500, ramp ticks without an accepted command before watchdog trip (WATCHDOG_EN only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  scheduler accepts command this cycle
- cmd_motor  in  IDX_W  target channel index
- cmd_dir  in  1  requested direction
- cmd_on  in  1  requested enable
- cmd_duty  in  5  requested duty, 0..31
- estop  in  1  level emergency stop
- cmd_err  out  1  one-cycle pulse: command with index >= NUM_MOTORS was dropped
- mot_dir  out  NUM_MOTORS  per-channel dir to motor_controller
- mot_on  out  NUM_MOTORS  per-channel on
- mot_duty  out  5*NUM_MOTORS  per-channel duty, channel k at bits [5k+4:5k]
- settled  out  NUM_MOTORS  channel k: current output equals target and state is not HOLD
- wdt_tripped  out  1  watchdog latched (WATCHDOG_EN only; otherwise tied 0)

Behaviour:
- Reset (async assert, sync release): all targets and current values 0; every channel state OFF.
  - Reset values: mot_on=0, mot_dir=0, mot_duty=0, settled=all 1, cmd_err=0, cmd_ready=0 while reset_n=0.
  - Prescaler cleared.
  - Reset mid-ramp or mid-HOLD aborts immediately to OFF.
- Handshake:
  - cmd_ready = !estop, registered-free.
  - Transfer occurs when cmd_valid && cmd_ready at a rising edge.
  - Target registers for cmd_motor update at that edge.
  - Index >= NUM_MOTORS: target unchanged; cmd_err=1 the following cycle.
  - Repeated commands overwrite the target; no queueing.
- Prescaler: counts 0..RAMP_DIV-1; tick is asserted for the cycle where count==RAMP_DIV-1, then the count wraps to 0. All channel FSMs advance only on tick.
- Per-channel FSM (evaluated on tick, using target values registered before that edge; a command landing on the tick edge takes effect at the next tick):
  - OFF: on=0, duty=0. If tgt_on: dir<=tgt_dir, on<=1, duty stays 0, go to RUN.
  - RUN, tgt_on=1 and tgt_dir==dir: duty steps +1 or -1 toward tgt_duty; equal means hold.
  - RUN, tgt_on=0 or tgt_dir!=dir: duty decrements by 1 per tick. At a tick where duty is already 0: on<=0, hold_cnt<=HOLD_TICKS-1, go to HOLD.
  - HOLD: on=0, duty=0. hold_cnt decrements each tick. At a tick with hold_cnt==0: if tgt_on, dir<=tgt_dir, on<=1, go to RUN; else go to OFF.
- Outputs are registered directly from per-channel state (zero combinational path from cmd_*).
- Duty arithmetic is 5-bit saturating; it never wraps past 0 or 31.
- estop (sampled each clk, not tick-gated): next edge forces every channel to OFF, on=0, duty=0, and clears every target's on bit. Targets stay cleared after estop deasserts until new commands arrive.

Optional Feature:
- Macro: MOTOR_RAMP_WATCHDOG_EN.
- Defined:
  - Tick counter is cleared on every accepted command.
  - When it reaches WDT_TICKS, all tgt_on bits are cleared (normal ramp-down/HOLD/OFF follows) and wdt_tripped is set.
  - wdt_tripped clears on the next accepted valid-index command.
- Undefined: no counter logic; wdt_tripped is constant 0.

Test Plan:
- RAMP_DIV=4, HOLD_TICKS=2. Command motor0 dir=1 on=1 duty=5 -> mot_on[0]=1 at first tick; mot_duty[4:0] reaches 1,2,3,4,5 on ticks 2-6 (4 clk apart); settled[0]=1 after 5.
- Motor0 at duty 3 dir=1, command dir=0 duty=3 -> duty 2,1,0 on successive ticks. Next tick on=0; 2 ticks HOLD; then dir=0, on=1; ramps 1,2,3. mot_dir never changes while mot_on=1.
- Motors 0 and 5 running at duty 10; assert estop for 1 clk -> next edge all mot_on=0, mot_duty=0, cmd_ready=0 during estop. After release, no restart without a new command.
- cmd_motor=7 with NUM_MOTORS=6 -> cmd_err pulses exactly 1 cycle; no output changes.
- Command arriving on the same edge as tick -> that tick uses the old target; the next tick uses the new target.
- MOTOR_RAMP_WATCHDOG_EN, WDT_TICKS=3, motor1 running at duty 2 -> after 3 command-free ticks wdt_tripped=1; motor1 ramps 1,0, enters HOLD, then OFF. A valid command clears wdt_tripped.

Source files
------------

// File: rtl/motor_ramp_scheduler.sv
// rtl/motor_ramp_scheduler.sv - set-point front-end that slews duty and sequences safe reversal per motor channel
// Optional command watchdog: define MOTOR_RAMP_WATCHDOG_EN.
module motor_ramp_scheduler #(
  parameter int NUM_MOTORS = 6,
  parameter int IDX_W      = 3,
  parameter int RAMP_DIV   = 50000,
  parameter int HOLD_TICKS = 20,
  parameter int WDT_TICKS  = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [IDX_W-1:0]        cmd_motor,
  input  logic                    cmd_dir,
  input  logic                    cmd_on,
  input  logic [4:0]              cmd_duty,
  input  logic                    estop,
  output logic                    cmd_err,
  output logic [NUM_MOTORS-1:0]   mot_dir,
  output logic [NUM_MOTORS-1:0]   mot_on,
  output logic [5*NUM_MOTORS-1:0] mot_duty,
  output logic [NUM_MOTORS-1:0]   settled,
  output logic                    wdt_tripped
);

  localparam int PW = $clog2(RAMP_DIV);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_HOLD} ch_state_t;

  if (RAMP_DIV < 2 || HOLD_TICKS < 1 || HOLD_TICKS > 255 || WDT_TICKS < 1 ||
      (1 << IDX_W) < NUM_MOTORS) begin : g_param_check
    $error("motor_ramp_scheduler: illegal parameter set");
  end

  ch_state_t             st_q     [NUM_MOTORS];
  ch_state_t             st_d     [NUM_MOTORS];
  logic [4:0]            duty_q   [NUM_MOTORS];
  logic [4:0]            duty_d   [NUM_MOTORS];
  logic [7:0]            hold_q   [NUM_MOTORS];
  logic [7:0]            hold_d   [NUM_MOTORS];
  logic [4:0]            tgt_duty_q [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] on_q, on_d, dir_q, dir_d;
  logic [NUM_MOTORS-1:0] tgt_on_q, tgt_dir_q;

  logic [PW-1:0] pre_q;
  logic          tick;
  logic          accept;
  logic          idx_ok;
  logic          wdt_fire;

  assign cmd_ready = reset_n && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign idx_ok    = int'(cmd_motor) < NUM_MOTORS;
  assign tick      = (pre_q == PW'(RAMP_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      cmd_err <= 1'b0;
    end else begin
      pre_q   <= tick ? '0 : pre_q + PW'(1);
      cmd_err <= accept && !idx_ok;
    end
  end

`ifdef MOTOR_RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  logic [WW-1:0] wdt_cnt_q;
  logic          wdt_trip_q;

  // Counter saturates at WDT_TICKS so a trip fires only once per silent period.
  assign wdt_fire    = !accept && tick && (wdt_cnt_q == WW'(WDT_TICKS - 1));
  assign wdt_tripped = wdt_trip_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_cnt_q  <= '0;
      wdt_trip_q <= 1'b0;
    end else if (accept) begin
      wdt_cnt_q <= '0;
      if (idx_ok) wdt_trip_q <= 1'b0;
    end else if (wdt_fire) begin
      wdt_cnt_q  <= WW'(WDT_TICKS);
      wdt_trip_q <= 1'b1;
    end else if (tick && wdt_cnt_q < WW'(WDT_TICKS - 1)) begin
      wdt_cnt_q <= wdt_cnt_q + WW'(1);
    end
  end
`else
  assign wdt_fire    = 1'b0;
  assign wdt_tripped = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_on_q  <= '0;
      tgt_dir_q <= '0;
      for (int k = 0; k < NUM_MOTORS; k++) tgt_duty_q[k] <= 5'd0;
    end else begin
      for (int k = 0; k < NUM_MOTORS; k++) begin
        if (estop) begin
          tgt_on_q[k] <= 1'b0;
        end else if (accept && idx_ok && cmd_motor == IDX_W'(k)) begin
          tgt_on_q[k]   <= cmd_on;
          tgt_dir_q[k]  <= cmd_dir;
          tgt_duty_q[k] <= cmd_duty;
        end else if (wdt_fire) begin
          tgt_on_q[k] <= 1'b0;
        end
      end
    end
  end

  // Channel FSMs read the targets registered before this edge, so a command
  // landing on a tick edge only takes effect at the following tick.
  always_comb begin
    for (int k = 0; k < NUM_MOTORS; k++) begin
      st_d[k]   = st_q[k];
      duty_d[k] = duty_q[k];
      hold_d[k] = hold_q[k];
      on_d[k]   = on_q[k];
      dir_d[k]  = dir_q[k];
      if (estop) begin
        st_d[k]   = ST_OFF;
        duty_d[k] = 5'd0;
        hold_d[k] = 8'd0;
        on_d[k]   = 1'b0;
      end else if (tick) begin
        unique case (st_q[k])
          ST_OFF: begin
            on_d[k]   = 1'b0;
            duty_d[k] = 5'd0;
            if (tgt_on_q[k]) begin
              dir_d[k] = tgt_dir_q[k];
              on_d[k]  = 1'b1;
              st_d[k]  = ST_RUN;
            end
          end
          ST_RUN: begin
            if (tgt_on_q[k] && tgt_dir_q[k] == dir_q[k]) begin
              if (duty_q[k] < tgt_duty_q[k])      duty_d[k] = duty_q[k] + 5'd1;
              else if (duty_q[k] > tgt_duty_q[k]) duty_d[k] = duty_q[k] - 5'd1;
            end else if (duty_q[k] == 5'd0) begin
              on_d[k]   = 1'b0;
              hold_d[k] = 8'(HOLD_TICKS - 1);
              st_d[k]   = ST_HOLD;
            end else begin
              duty_d[k] = duty_q[k] - 5'd1;
            end
          end
          ST_HOLD: begin
            on_d[k]   = 1'b0;
            duty_d[k] = 5'd0;
            if (hold_q[k] == 8'd0) begin
              if (tgt_on_q[k]) begin
                dir_d[k] = tgt_dir_q[k];
                on_d[k]  = 1'b1;
                st_d[k]  = ST_RUN;
              end else begin
                st_d[k] = ST_OFF;
              end
            end else begin
              hold_d[k] = hold_q[k] - 8'd1;
            end
          end
          default: st_d[k] = ST_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      on_q  <= '0;
      dir_q <= '0;
      for (int k = 0; k < NUM_MOTORS; k++) begin
        st_q[k]   <= ST_OFF;
        duty_q[k] <= 5'd0;
        hold_q[k] <= 8'd0;
      end
    end else begin
      on_q  <= on_d;
      dir_q <= dir_d;
      for (int k = 0; k < NUM_MOTORS; k++) begin
        st_q[k]   <= st_d[k];
        duty_q[k] <= duty_d[k];
        hold_q[k] <= hold_d[k];
      end
    end
  end

  assign mot_on  = on_q;
  assign mot_dir = dir_q;

  always_comb begin
    mot_duty = '0;
    settled  = '0;
    for (int k = 0; k < NUM_MOTORS; k++) begin
      mot_duty[5*k +: 5] = duty_q[k];
      settled[k] = (st_q[k] != ST_HOLD) && (on_q[k] == tgt_on_q[k]) &&
                   (duty_q[k] == (tgt_on_q[k] ? tgt_duty_q[k] : 5'd0)) &&
                   (!tgt_on_q[k] || dir_q[k] == tgt_dir_q[k]);
    end
  end

endmodule
